core_boot_ctrl: RTL and testbench
=================================

# core_boot_ctrl

Boot and run sequencer for the single-cycle RISC-V core. It accepts a program as a byte stream and writes it word by word into instruction memory while holding the core in reset. It then releases the core and stops it again on EBREAK or on a cycle-budget timeout. It sits between the host or loader link and the core's reset and instruction-memory write port, and reports run status and cycle count.

## Interface
- `IMEM_WORDS`, 256: instruction memory depth in 32-bit words.
- `AW`, 8: instruction memory word-address width; must satisfy 2^AW >= IMEM_WORDS.
- `MAX_CYCLES`, 32'd1_000_000: run-cycle budget before forced stop.

- `i_clk`  in  1  single clock.
- `i_rst_n`  in  1  reset, asynchronous, active-low.
- `i_rx_data`  in  8  stream byte.
- `i_rx_valid`  in  1  byte valid.
- `o_rx_ready`  out  1  byte accepted when valid && ready.
- `o_imem_we`  out  1  instruction memory write strobe, 1-cycle pulse.
- `o_imem_addr`  out  AW  word address.
- `o_imem_wdata`  out  32  word data.
- `i_instr`  in  32  instruction currently fetched by the core.
- `o_core_rst_n`  out  1  core reset, active-low.
- `o_halted`  out  1  core stopped by EBREAK.
- `o_timeout`  out  1  core stopped by budget.
- `o_error`  out  1  bad header; sticky until reset.
- `o_cycles`  out  32  run-cycle count.

## Operation
- States: HDR, LOAD, RUN, DONE, ERR. Encoding lives in the package.
- Reset values: state HDR; o_core_rst_n=0; o_imem_we=0; o_imem_addr=0; o_imem_wdata=0; o_halted=0; o_timeout=0; o_error=0; o_cycles=0; internal byte counter and word count = 0.
- o_rx_ready is decoded from state: 1 in HDR, LOAD and DONE; 0 in RUN and ERR.
- **HDR**: accept 2 bytes forming little-endian 16-bit word count N.
  - N==0 or N>IMEM_WORDS -> ERR.
  - Otherwise -> LOAD, with the word address cleared to 0.
- **LOAD**: accept 4N bytes. Each group of 4 is packed little-endian (first byte = bits 7:0).
  - After the 4th byte, the word is written at the current address, then the address increments.
  - After word N-1 is written -> RUN.
- **RUN**: o_core_rst_n=1. o_cycles increments on every clock edge spent in RUN, including the exit edge.
  - If i_instr == 32'h00100073 (EBREAK) -> DONE, o_halted=1.
  - Else if o_cycles == MAX_CYCLES -> DONE, o_timeout=1.
  - EBREAK has priority over timeout when both hold in the same cycle.
- **DONE**: o_core_rst_n=0.
  - o_cycles, o_halted and o_timeout are held.
  - An accepted byte is taken as header byte 0 of a new load: -> HDR with 1 header byte consumed, o_halted and o_timeout cleared.
  - o_cycles is cleared only on the next RUN entry.
- **ERR**: o_error=1, o_core_rst_n=0, no bytes accepted. Only i_rst_n exits ERR.
- Asserting i_rst_n in any state, mid-word or mid-run, restores the reset values immediately. Partial words are discarded.
- Bytes presented while ready=0 are not consumed; the source must hold them.

## Timing
- Word write: o_imem_we, o_imem_addr and o_imem_wdata are registered and valid in the cycle after the edge that accepts the 4th byte. Latency is 1 cycle.
- Back-to-back bytes (valid held high) are accepted one per cycle. There is no bubble between words.
- RUN entry: state->RUN, o_core_rst_n->1 and o_cycles->0 all update on the same edge, the edge after the last word's write pulse. The last word is therefore in memory before the core fetches PC 0.
- Stop: state->DONE and o_core_rst_n->0 update on the edge that samples EBREAK or the budget limit.
  - Example: EBREAK at PC 0 gives o_cycles=1 and o_halted=1.
- o_cycles saturates at MAX_CYCLES and never wraps.

## Structure
- Shared package/header `riscv_pkg` holds:
  - state encoding `BOOT_HDR`, `BOOT_LOAD`, `BOOT_RUN`, `BOOT_DONE`, `BOOT_ERR`;
  - `INSTR_EBREAK` = 32'h00100073.
- One sub-module, `byte_word_packer`, handles 8->32 little-endian packing. It has a byte valid input, a 2-bit lane counter, a word-valid pulse output and a synchronous clear.
- The FSM, address/word counters and cycle counter live in `core_boot_ctrl`.

## Test plan
- Header 02 00, bytes 13 00 00 00 73 00 10 00 -> write pulses: addr0=32'h00000013, addr1=32'h00100073. Core released one cycle later; core reaches EBREAK -> o_halted=1, o_core_rst_n=0, o_cycles equal to the run edges counted.
- Header 00 00 -> o_error=1, o_rx_ready=0, o_core_rst_n stays 0; any further bytes are ignored until reset.
- Header 01 01 (N=257) with IMEM_WORDS=256 -> ERR.
- MAX_CYCLES=10, program of a single NOP loop (32'h0000006F) -> DONE with o_timeout=1 and o_cycles=10. EBREAK and limit in the same cycle -> o_halted=1, o_timeout=0.
- i_rst_n pulsed low after 6 of 8 load bytes -> all outputs at reset values. A fresh load then writes from addr 0 with no stale lanes.
- A new header arriving in DONE -> flags cleared, reload proceeds, o_cycles resets to 0 on the second RUN entry. Random valid gaps in the stream -> identical writes.

Source files
------------

// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
//  Package   : riscv_pkg
//  Purpose   : Shared definitions for the single-cycle RISC-V core slice:
//              boot sequencer state encoding and well-known instruction words.
//  Revision  : 1.0  initial release
// ============================================================================
package riscv_pkg;

   typedef enum logic [2:0] {
      BOOT_HDR  = 3'd0,
      BOOT_LOAD = 3'd1,
      BOOT_RUN  = 3'd2,
      BOOT_DONE = 3'd3,
      BOOT_ERR  = 3'd4
   } boot_state_e;

   localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

endpackage
`default_nettype wire

// File: rtl/core_boot_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Interface : core_boot_ctrl_if
//  Purpose   : Bundles the boot sequencer's loader byte stream, instruction
//              memory write port, core control and status signals.
//  Modports  : master - the boot controller (drives o_* signals)
//              slave  - the host/loader + core side (drives i_* signals)
//  Signals   : i_rx_data/i_rx_valid/o_rx_ready   byte stream handshake
//              o_imem_we/o_imem_addr/o_imem_wdata instruction memory write
//              i_instr                            instruction fetched by core
//              o_core_rst_n                       core reset, active-low
//              o_halted/o_timeout/o_error         run status
//              o_cycles                           run-cycle count
//  Revision  : 1.0  initial release
// ============================================================================
interface core_boot_ctrl_if #(
   parameter int AW = 8
);
   logic [7:0]    i_rx_data;
   logic          i_rx_valid;
   logic          o_rx_ready;
   logic          o_imem_we;
   logic [AW-1:0] o_imem_addr;
   logic [31:0]   o_imem_wdata;
   logic [31:0]   i_instr;
   logic          o_core_rst_n;
   logic          o_halted;
   logic          o_timeout;
   logic          o_error;
   logic [31:0]   o_cycles;

   modport master (
      input  i_rx_data, i_rx_valid, i_instr,
      output o_rx_ready, o_imem_we, o_imem_addr, o_imem_wdata,
             o_core_rst_n, o_halted, o_timeout, o_error, o_cycles
   );

   modport slave (
      output i_rx_data, i_rx_valid, i_instr,
      input  o_rx_ready, o_imem_we, o_imem_addr, o_imem_wdata,
             o_core_rst_n, o_halted, o_timeout, o_error, o_cycles
   );
endinterface
`default_nettype wire

// File: rtl/byte_word_packer.sv
`default_nettype none
// ============================================================================
//  Module    : byte_word_packer
//  Purpose   : Packs a byte stream into 32-bit little-endian words (first byte
//              lands in bits 7:0). Emits a registered 1-cycle word-valid pulse
//              in the cycle after the 4th byte is taken.
//  Ports     : i_clk, i_rst_n  clock, async active-low reset
//              i_clr           synchronous clear of lane counter and partials
//              i_valid/i_byte  byte to pack (consumed when i_valid)
//              o_word          last completed word (held between pulses)
//              o_word_valid    1-cycle pulse, o_word is new
//  Revision  : 1.0  initial release
// ============================================================================
module byte_word_packer (
   input  wire logic        i_clk,
   input  wire logic        i_rst_n,
   input  wire logic        i_clr,
   input  wire logic        i_valid,
   input  wire logic [7:0]  i_byte,
   output logic      [31:0] o_word,
   output logic             o_word_valid
);

   logic [1:0]  lane_q, lane_d;
   logic [23:0] part_q, part_d;
   logic [31:0] word_q, word_d;
   logic        word_valid_q, word_valid_d;

   always_comb begin
      lane_d       = lane_q;
      part_d       = part_q;
      word_d       = word_q;
      word_valid_d = 1'b0;
      if (i_clr) begin
         // Drop any partial word so a fresh load never sees stale lanes.
         lane_d = 2'd0;
         part_d = 24'd0;
      end else if (i_valid) begin
         case (lane_q)
            2'd0:    part_d[7:0]   = i_byte;
            2'd1:    part_d[15:8]  = i_byte;
            2'd2:    part_d[23:16] = i_byte;
            default: begin
               word_d       = {i_byte, part_q};
               word_valid_d = 1'b1;
            end
         endcase
         lane_d = lane_q + 2'd1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         lane_q       <= 2'd0;
         part_q       <= 24'd0;
         word_q       <= 32'd0;
         word_valid_q <= 1'b0;
      end else begin
         lane_q       <= lane_d;
         part_q       <= part_d;
         word_q       <= word_d;
         word_valid_q <= word_valid_d;
      end
   end

   assign o_word       = word_q;
   assign o_word_valid = word_valid_q;

endmodule
`default_nettype wire

// File: rtl/core_boot_ctrl.sv
`default_nettype none
// ============================================================================
//  Module    : core_boot_ctrl
//  Purpose   : Boot and run sequencer for the single-cycle RISC-V core.
//              Takes a header (16-bit LE word count N) and 4N program bytes,
//              writes them into instruction memory with the core held in
//              reset, then releases the core until EBREAK or cycle budget.
//  Ports     : i_clk, i_rst_n  clock, async active-low reset
//              bus (master)    byte stream, imem write port, core control,
//                              status and cycle count (see core_boot_ctrl_if)
//  Params    : IMEM_WORDS  instruction memory depth (words)
//              AW          word-address width, 2**AW >= IMEM_WORDS
//              MAX_CYCLES  run-cycle budget before forced stop
//  Revision  : 1.0  initial release
// ============================================================================
module core_boot_ctrl
   import riscv_pkg::*;
#(
   parameter int          IMEM_WORDS = 256,
   parameter int          AW         = 8,
   parameter logic [31:0] MAX_CYCLES = 32'd1_000_000
) (
   input  wire logic          i_clk,
   input  wire logic          i_rst_n,
   core_boot_ctrl_if.master   bus
);

   localparam logic [16:0] MAX_WORDS = 17'(IMEM_WORDS);

   boot_state_e   state_q, state_d;
   logic          hdr_cnt_q, hdr_cnt_d;     // header bytes already consumed
   logic [7:0]    hdr_lo_q, hdr_lo_d;
   logic [15:0]   n_q, n_d;                 // words to load
   logic [AW-1:0] addr_q, addr_d;
   logic [31:0]   cycles_q, cycles_d;
   logic          halted_q, halted_d;
   logic          timeout_q, timeout_d;

   logic          rx_ready;
   logic          accept;
   logic [15:0]   hdr_word;
   logic [31:0]   pk_word;
   logic          pk_word_valid;

   always_comb begin
      rx_ready = 1'b0;
      case (state_q)
         BOOT_HDR, BOOT_LOAD, BOOT_DONE: rx_ready = 1'b1;
         default:                        rx_ready = 1'b0;
      endcase
   end

   assign accept   = bus.i_rx_valid & rx_ready;
   assign hdr_word = {bus.i_rx_data, hdr_lo_q};

   byte_word_packer u_packer (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_clr        (state_q != BOOT_LOAD),
      .i_valid      (accept && (state_q == BOOT_LOAD)),
      .i_byte       (bus.i_rx_data),
      .o_word       (pk_word),
      .o_word_valid (pk_word_valid)
   );

   always_comb begin
      state_d   = state_q;
      hdr_cnt_d = hdr_cnt_q;
      hdr_lo_d  = hdr_lo_q;
      n_d       = n_q;
      addr_d    = addr_q;
      cycles_d  = cycles_q;
      halted_d  = halted_q;
      timeout_d = timeout_q;

      case (state_q)
         BOOT_HDR: begin
            if (accept) begin
               if (!hdr_cnt_q) begin
                  hdr_lo_d  = bus.i_rx_data;
                  hdr_cnt_d = 1'b1;
               end else begin
                  hdr_cnt_d = 1'b0;
                  if ((hdr_word == 16'd0) || ({1'b0, hdr_word} > MAX_WORDS)) begin
                     state_d = BOOT_ERR;
                  end else begin
                     state_d = BOOT_LOAD;
                     n_d     = hdr_word;
                     addr_d  = '0;
                  end
               end
            end
         end

         BOOT_LOAD: begin
            // The address steps on the edge that ends the write pulse; the
            // final word's pulse edge is also the RUN entry edge.
            if (pk_word_valid) begin
               addr_d = addr_q + 1'b1;
               if (16'(addr_q) == (n_q - 16'd1)) begin
                  state_d  = BOOT_RUN;
                  cycles_d = 32'd0;
               end
            end
         end

         BOOT_RUN: begin
            cycles_d = (cycles_q == MAX_CYCLES) ? cycles_q : cycles_q + 32'd1;
            if (bus.i_instr == INSTR_EBREAK) begin
               state_d  = BOOT_DONE;
               halted_d = 1'b1;
            end else if (cycles_q == MAX_CYCLES) begin
               state_d   = BOOT_DONE;
               timeout_d = 1'b1;
            end
         end

         BOOT_DONE: begin
            // A byte here is header byte 0 of the next program.
            if (accept) begin
               state_d   = BOOT_HDR;
               hdr_lo_d  = bus.i_rx_data;
               hdr_cnt_d = 1'b1;
               halted_d  = 1'b0;
               timeout_d = 1'b0;
            end
         end

         BOOT_ERR: begin
            state_d = BOOT_ERR;
         end

         default: begin
            state_d = BOOT_HDR;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= BOOT_HDR;
         hdr_cnt_q <= 1'b0;
         hdr_lo_q  <= 8'd0;
         n_q       <= 16'd0;
         addr_q    <= '0;
         cycles_q  <= 32'd0;
         halted_q  <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         hdr_cnt_q <= hdr_cnt_d;
         hdr_lo_q  <= hdr_lo_d;
         n_q       <= n_d;
         addr_q    <= addr_d;
         cycles_q  <= cycles_d;
         halted_q  <= halted_d;
         timeout_q <= timeout_d;
      end
   end

   assign bus.o_rx_ready   = rx_ready;
   assign bus.o_imem_we    = pk_word_valid;
   assign bus.o_imem_addr  = addr_q;
   assign bus.o_imem_wdata = pk_word;
   assign bus.o_core_rst_n = (state_q == BOOT_RUN);
   assign bus.o_halted     = halted_q;
   assign bus.o_timeout    = timeout_q;
   assign bus.o_error      = (state_q == BOOT_ERR);
   assign bus.o_cycles     = cycles_q;

endmodule
`default_nettype wire

// File: tb/tb_core_boot_ctrl.sv
`default_nettype none
// ============================================================================
//  Module    : tb_core_boot_ctrl
//  Purpose   : Self-checking bench for core_boot_ctrl. Expected memory writes
//              are queued as program bytes are sent and checked as write
//              pulses appear; run/stop behaviour is checked per scenario.
//  Revision  : 1.0  initial release
// ============================================================================
module tb_core_boot_ctrl;
   import riscv_pkg::*;

   localparam int          AW     = 8;
   localparam logic [31:0] MAXC   = 32'd10;
   localparam logic [31:0] NOP    = 32'h0000_0013;
   localparam logic [31:0] JLOOP  = 32'h0000_006F;
   localparam logic [77:0] RST_VEC = 78'd1;   // only o_rx_ready high

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   core_boot_ctrl_if #(.AW(AW)) bif ();

   core_boot_ctrl #(
      .IMEM_WORDS (256),
      .AW         (AW),
      .MAX_CYCLES (MAXC)
   ) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bif.master)
   );

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [31:0]   data;
   } wr_t;

   wr_t         exp_q[$];
   wr_t         mon_e;
   logic [31:0] prog[$];
   int          n_tests = 0;
   int          n_fail  = 0;

   function automatic logic [77:0] out_vec();
      return {bif.o_core_rst_n, bif.o_imem_we, bif.o_imem_addr, bif.o_imem_wdata,
              bif.o_halted, bif.o_timeout, bif.o_error, bif.o_cycles, bif.o_rx_ready};
   endfunction

   // Scoreboard: every write pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      if (rst_n && bif.o_imem_we) begin
         n_tests++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL imem_write unexpected: addr=%0h data=%h, required no write",
                     bif.o_imem_addr, bif.o_imem_wdata);
         end else begin
            mon_e = exp_q.pop_front();
            if (bif.o_imem_addr !== mon_e.addr || bif.o_imem_wdata !== mon_e.data) begin
               n_fail++;
               $display("FAIL imem_write: got addr=%0h data=%h, required addr=%0h data=%h",
                        bif.o_imem_addr, bif.o_imem_wdata, mon_e.addr, mon_e.data);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, required finish");
      $fatal(1, "watchdog");
   end

   task automatic align();
      @(posedge clk);
      #1;
   endtask

   function automatic int pick_gap(input int gap_max);
      return (gap_max == 0) ? 0 : int'($urandom_range(gap_max, 0));
   endfunction

   // Presents one byte and holds it until accepted (bounded). Assumes it
   // starts just after a rising edge; leaves just after the accepting edge.
   task automatic send_byte(input logic [7:0] b, input int gap);
      int   cnt;
      logic acc;
      if (gap > 0) begin
         repeat (gap) @(posedge clk);
         #1;
      end
      bif.i_rx_data  = b;
      bif.i_rx_valid = 1'b1;
      cnt = 0;
      acc = 1'b0;
      while (!acc && cnt < 50) begin
         @(negedge clk);
         acc = bif.o_rx_ready;
         @(posedge clk);
         #1;
         cnt++;
      end
      bif.i_rx_valid = 1'b0;
      if (!acc) begin
         n_tests++;
         n_fail++;
         $display("FAIL send_byte: byte %h not accepted in 50 cycles, required accept", b);
      end
   endtask

   task automatic load_program(input int gap_max);
      int          n;
      logic [31:0] w;
      logic [7:0]  b;
      wr_t         e;
      n = prog.size();
      send_byte(8'(n), pick_gap(gap_max));
      send_byte(8'(n >> 8), pick_gap(gap_max));
      for (int i = 0; i < n; i++) begin
         w      = prog[i];
         e.addr = AW'(i);
         e.data = w;
         exp_q.push_back(e);
         for (int k = 0; k < 4; k++) begin
            b = w[8*k +: 8];
            send_byte(b, pick_gap(gap_max));
         end
      end
   endtask

   task automatic wait_release(output bit ok);
      ok = 1'b0;
      for (int c = 0; c < 20 && !ok; c++) begin
         @(negedge clk);
         if (bif.o_core_rst_n === 1'b1) ok = 1'b1;
      end
   endtask

   task automatic wait_stop(output bit ok);
      ok = 1'b0;
      for (int c = 0; c < 40 && !ok; c++) begin
         @(negedge clk);
         if (bif.o_core_rst_n === 1'b0) ok = 1'b1;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n          = 1'b0;
      bif.i_rx_valid = 1'b0;
      bif.i_instr    = 32'd0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      exp_q.delete();
      align();
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      n_tests++;
      if (out_vec() !== RST_VEC) begin
         n_fail++;
         $display("FAIL reset_hold: got %h, required %h", out_vec(), RST_VEC);
      end
      rst_n = 1'b1;
      align();
      n_tests++;
      if (out_vec() !== RST_VEC) begin
         n_fail++;
         $display("FAIL reset_idle: got %h, required %h", out_vec(), RST_VEC);
      end
   endtask

   task automatic test_load_ebreak();
      bit ok;
      prog.delete();
      prog.push_back(NOP);
      prog.push_back(INSTR_EBREAK);
      load_program(0);
      wait_release(ok);
      n_tests++;
      if (!ok || exp_q.size() != 0 || bif.o_cycles !== 32'd0 || bif.o_rx_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL run_entry: released=%0d pending=%0d cycles=%0d ready=%b, required 1 0 0 0",
                  ok, exp_q.size(), bif.o_cycles, bif.o_rx_ready);
      end
      bif.i_instr = NOP;
      repeat (3) @(negedge clk);
      n_tests++;
      if (bif.o_cycles !== 32'd3 || bif.o_core_rst_n !== 1'b1) begin
         n_fail++;
         $display("FAIL run_count: cycles=%0d core_rst_n=%b, required 3 1",
                  bif.o_cycles, bif.o_core_rst_n);
      end
      bif.i_instr = INSTR_EBREAK;
      @(negedge clk);
      bif.i_instr = 32'd0;
      n_tests++;
      if ({bif.o_halted, bif.o_timeout, bif.o_core_rst_n, bif.o_rx_ready} !== 4'b1001 ||
          bif.o_cycles !== 32'd4) begin
         n_fail++;
         $display("FAIL ebreak_stop: halt/tmo/rst/rdy=%b%b%b%b cycles=%0d, required 1001 4",
                  bif.o_halted, bif.o_timeout, bif.o_core_rst_n, bif.o_rx_ready, bif.o_cycles);
      end
      repeat (3) @(negedge clk);
      n_tests++;
      if (bif.o_cycles !== 32'd4 || bif.o_halted !== 1'b1) begin
         n_fail++;
         $display("FAIL done_hold: cycles=%0d halted=%b, required 4 1", bif.o_cycles, bif.o_halted);
      end
   endtask

   task automatic test_timeout();
      bit ok;
      prog.delete();
      prog.push_back(JLOOP);
      align();
      load_program(0);
      wait_release(ok);
      n_tests++;
      if (!ok || bif.o_cycles !== 32'd0 || bif.o_halted !== 1'b0 || bif.o_timeout !== 1'b0) begin
         n_fail++;
         $display("FAIL reload_entry: released=%0d cycles=%0d halted=%b timeout=%b, required 1 0 0 0",
                  ok, bif.o_cycles, bif.o_halted, bif.o_timeout);
      end
      bif.i_instr = JLOOP;
      wait_stop(ok);
      bif.i_instr = 32'd0;
      n_tests++;
      if (!ok || bif.o_timeout !== 1'b1 || bif.o_halted !== 1'b0 || bif.o_cycles !== MAXC) begin
         n_fail++;
         $display("FAIL timeout_stop: stopped=%0d timeout=%b halted=%b cycles=%0d, required 1 1 0 %0d",
                  ok, bif.o_timeout, bif.o_halted, bif.o_cycles, MAXC);
      end
   endtask

   task automatic test_ebreak_at_limit();
      bit ok;
      prog.delete();
      prog.push_back(JLOOP);
      align();
      load_program(3);
      wait_release(ok);
      n_tests++;
      if (!ok || bif.o_timeout !== 1'b0 || exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL gap_load: released=%0d timeout=%b pending=%0d, required 1 0 0",
                  ok, bif.o_timeout, exp_q.size());
      end
      bif.i_instr = JLOOP;
      ok = 1'b0;
      for (int c = 0; c < 30 && !ok; c++) begin
         @(negedge clk);
         if (bif.o_cycles === MAXC && bif.o_core_rst_n === 1'b1) ok = 1'b1;
      end
      bif.i_instr = INSTR_EBREAK;
      @(negedge clk);
      bif.i_instr = 32'd0;
      n_tests++;
      if (!ok || bif.o_halted !== 1'b1 || bif.o_timeout !== 1'b0 || bif.o_cycles !== MAXC) begin
         n_fail++;
         $display("FAIL ebreak_priority: reached=%0d halted=%b timeout=%b cycles=%0d, required 1 1 0 %0d",
                  ok, bif.o_halted, bif.o_timeout, bif.o_cycles, MAXC);
      end
   endtask

   task automatic test_back_to_back();
      bit  ok;
      time t0;
      prog.delete();
      prog.push_back(32'h1234_5678);
      prog.push_back(32'h9ABC_DEF0);
      prog.push_back(32'h0F0E_0D0C);
      prog.push_back(INSTR_EBREAK);
      align();
      t0 = $time;
      load_program(0);
      n_tests++;
      if (($time - t0) !== 64'd180) begin
         n_fail++;
         $display("FAIL back_to_back: 18 bytes took %0d time units, required 180", $time - t0);
      end
      wait_release(ok);
      bif.i_instr = INSTR_EBREAK;
      @(negedge clk);
      bif.i_instr = 32'd0;
      n_tests++;
      if (!ok || bif.o_cycles !== 32'd1 || bif.o_halted !== 1'b1 || exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL pc0_ebreak: released=%0d cycles=%0d halted=%b pending=%0d, required 1 1 1 0",
                  ok, bif.o_cycles, bif.o_halted, exp_q.size());
      end
   endtask

   task automatic test_bad_header_zero();
      logic saw_ready;
      do_reset();
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
      @(negedge clk);
      n_tests++;
      if ({bif.o_error, bif.o_rx_ready, bif.o_core_rst_n} !== 3'b100) begin
         n_fail++;
         $display("FAIL hdr_zero: err/rdy/rst=%b%b%b, required 100",
                  bif.o_error, bif.o_rx_ready, bif.o_core_rst_n);
      end
      bif.i_rx_data  = 8'h55;
      bif.i_rx_valid = 1'b1;
      saw_ready = 1'b0;
      repeat (5) begin
         @(negedge clk);
         if (bif.o_rx_ready !== 1'b0 || bif.o_error !== 1'b1) saw_ready = 1'b1;
      end
      bif.i_rx_valid = 1'b0;
      n_tests++;
      if (saw_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL err_sticky: left ERR or became ready=%b, required 0", saw_ready);
      end
      do_reset();
      n_tests++;
      if (bif.o_error !== 1'b0) begin
         n_fail++;
         $display("FAIL err_reset: error=%b, required 0", bif.o_error);
      end
   endtask

   task automatic test_bad_header_large();
      send_byte(8'h01, 0);
      send_byte(8'h01, 0);
      @(negedge clk);
      n_tests++;
      if (bif.o_error !== 1'b1 || bif.o_rx_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL hdr_257: error=%b ready=%b, required 1 0", bif.o_error, bif.o_rx_ready);
      end
      do_reset();
      send_byte(8'h00, 0);
      send_byte(8'h01, 0);
      @(negedge clk);
      n_tests++;
      if (bif.o_error !== 1'b0 || bif.o_rx_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL hdr_256: error=%b ready=%b, required 0 1", bif.o_error, bif.o_rx_ready);
      end
   endtask

   task automatic test_reset_midload();
      bit  ok;
      wr_t e;
      do_reset();
      e.addr = '0;
      e.data = 32'hDDCC_BBAA;
      exp_q.push_back(e);
      send_byte(8'h02, 0);
      send_byte(8'h00, 0);
      send_byte(8'hAA, 0);
      send_byte(8'hBB, 0);
      send_byte(8'hCC, 0);
      send_byte(8'hDD, 0);
      send_byte(8'h11, 0);
      send_byte(8'h22, 0);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      n_tests++;
      if (out_vec() !== RST_VEC || exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL midload_reset: got %h pending=%0d, required %h 0",
                  out_vec(), exp_q.size(), RST_VEC);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      exp_q.delete();
      prog.delete();
      prog.push_back(32'hCAFE_F00D);
      prog.push_back(32'h0000_0001);
      align();
      load_program(2);
      wait_release(ok);
      n_tests++;
      if (!ok || exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL fresh_load: released=%0d pending=%0d, required 1 0", ok, exp_q.size());
      end
      bif.i_instr = INSTR_EBREAK;
      @(negedge clk);
      bif.i_instr = 32'd0;
   endtask

   initial begin
      bif.i_rx_data  = 8'd0;
      bif.i_rx_valid = 1'b0;
      bif.i_instr    = 32'd0;
      test_reset();
      test_load_ebreak();
      test_timeout();
      test_ebreak_at_limit();
      test_back_to_back();
      test_bad_header_zero();
      test_bad_header_large();
      test_reset_midload();
      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
